// File: rtl/register_file_scoreboard_pkg.sv
// Shared constants, types and hit helpers for the register file and its
// pending-write scoreboard.
package register_file_scoreboard_pkg;

  localparam int NUM_REGS     = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;
  localparam logic [CNT_W:0]        MAX_CNT  = (CNT_W+1)'(MAX_INFLIGHT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
  } reg_event_t;

  // Register 0 never tracks writes, so events aimed at it never hit.
  function automatic logic hits(reg_event_t ev, reg_addr_t r);
    return ev.valid && (ev.addr == r) && (r != REG_ZERO);
  endfunction

  function automatic logic [1:0] dec_for(reg_event_t wb, reg_event_t cn, reg_addr_t r);
    return {1'b0, hits(wb, r)} + {1'b0, hits(cn, r)};
  endfunction

endpackage

// File: rtl/register_file_scoreboard_pending_write_counter.sv
// Saturating up/down count of outstanding writes to one register; err flags
// an underflow or overflow on the current update.
module pending_write_counter
  import register_file_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic [1:0] dec,
  output cnt_t       cnt,
  output logic       err
);

  cnt_t           cnt_q, cnt_d;
  logic [CNT_W:0] up;
  logic [CNT_W:0] dec_ext;
  logic [CNT_W:0] net;

  always_comb begin
    up      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
    dec_ext = {{(CNT_W-1){1'b0}}, dec};
    net     = '0;
    cnt_d   = cnt_q;
    err     = 1'b0;
    if (dec_ext > up) begin
      cnt_d = '0;
      err   = 1'b1;
    end else begin
      net = up - dec_ext;
      if (net > MAX_CNT) begin
        cnt_d = MAX_CNT[CNT_W-1:0];
        err   = 1'b1;
      end else begin
        cnt_d = net[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// 32x32 MIPS register file with write-through read bypass and a per-register
// pending-write scoreboard that stalls decode on RAW hazards or full counters.
module register_file_scoreboard
  import register_file_scoreboard_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] ReadReg1In,
  input  logic [REG_ADDR_W-1:0] ReadReg2In,
  input  logic                  Use1In,
  input  logic                  Use2In,
  output logic [DATA_W-1:0]     ReadData1Out,
  output logic [DATA_W-1:0]     ReadData2Out,
  input  logic                  IssueRegWriteIn,
  input  logic [REG_ADDR_W-1:0] IssueDestRegIn,
  input  logic                  RegWriteIn,
  input  logic [REG_ADDR_W-1:0] DestinationRegIn,
  input  logic [DATA_W-1:0]     RegWriteDataIn,
  input  logic                  CancelValidIn,
  input  logic [REG_ADDR_W-1:0] CancelDestRegIn,
  output logic                  StallOut,
  output logic                  ScoreboardErrorOut
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt;
  logic [NUM_REGS-1:1]             inc_vec;
  logic [NUM_REGS-1:1]             err_vec;
  logic [NUM_REGS-1:1][1:0]        dec_vec;
  logic                            err_q, err_d;
  reg_event_t                      wb, cn, iss;
  logic [1:0]                      dec_rd1, dec_rd2, dec_iss;
  logic                            raw_stall, full_stall, stall;

  assign wb  = {RegWriteIn, DestinationRegIn};
  assign cn  = {CancelValidIn, CancelDestRegIn};
  assign iss = {IssueRegWriteIn, IssueDestRegIn};

  // A write-back or cancel landing this cycle already counts toward releasing the hazard.
  always_comb begin
    dec_rd1    = dec_for(wb, cn, ReadReg1In);
    dec_rd2    = dec_for(wb, cn, ReadReg2In);
    dec_iss    = dec_for(wb, cn, IssueDestRegIn);
    raw_stall  = (Use1In && (ReadReg1In != REG_ZERO) &&
                  ({1'b0, cnt[ReadReg1In]} > {{(CNT_W-1){1'b0}}, dec_rd1})) ||
                 (Use2In && (ReadReg2In != REG_ZERO) &&
                  ({1'b0, cnt[ReadReg2In]} > {{(CNT_W-1){1'b0}}, dec_rd2}));
    full_stall = hits(iss, IssueDestRegIn) &&
                 ({1'b0, cnt[IssueDestRegIn]} >= (MAX_CNT + {{(CNT_W-1){1'b0}}, dec_iss}));
    stall      = raw_stall || full_stall;
  end

  assign StallOut = stall;

  assign cnt[0] = '0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    assign inc_vec[r] = hits(iss, REG_ADDR_W'(r)) && !stall;
    assign dec_vec[r] = dec_for(wb, cn, REG_ADDR_W'(r));
    pending_write_counter u_cnt (
      .clk (Clk),
      .rst (Rst),
      .inc (inc_vec[r]),
      .dec (dec_vec[r]),
      .cnt (cnt[r]),
      .err (err_vec[r])
    );
  end

  always_comb begin
    regs_d = regs_q;
    if (hits(wb, DestinationRegIn)) regs_d[DestinationRegIn] = RegWriteDataIn;
    regs_d[0] = '0;
    err_d = err_q | (|err_vec);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      regs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  assign ScoreboardErrorOut = err_q;

  always_comb begin
    ReadData1Out = regs_q[ReadReg1In];
    if (ReadReg1In == REG_ZERO)
      ReadData1Out = '0;
    else if (RegWriteIn && (DestinationRegIn == ReadReg1In))
      ReadData1Out = RegWriteDataIn;
  end

  always_comb begin
    ReadData2Out = regs_q[ReadReg2In];
    if (ReadReg2In == REG_ZERO)
      ReadData2Out = '0;
    else if (RegWriteIn && (DestinationRegIn == ReadReg2In))
      ReadData2Out = RegWriteDataIn;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: the driver pushes model-predicted outputs per cycle, a
// negedge monitor pops them and compares against the DUT.
module tb_register_file_scoreboard;

  localparam int MAXF = 4;

  logic        Clk;
  logic        Rst;
  logic [4:0]  ReadReg1In, ReadReg2In;
  logic        Use1In, Use2In;
  logic [31:0] ReadData1Out, ReadData2Out;
  logic        IssueRegWriteIn;
  logic [4:0]  IssueDestRegIn;
  logic        RegWriteIn;
  logic [4:0]  DestinationRegIn;
  logic [31:0] RegWriteDataIn;
  logic        CancelValidIn;
  logic [4:0]  CancelDestRegIn;
  logic        StallOut;
  logic        ScoreboardErrorOut;

  register_file_scoreboard dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .ReadReg1In         (ReadReg1In),
    .ReadReg2In         (ReadReg2In),
    .Use1In             (Use1In),
    .Use2In             (Use2In),
    .ReadData1Out       (ReadData1Out),
    .ReadData2Out       (ReadData2Out),
    .IssueRegWriteIn    (IssueRegWriteIn),
    .IssueDestRegIn     (IssueDestRegIn),
    .RegWriteIn         (RegWriteIn),
    .DestinationRegIn   (DestinationRegIn),
    .RegWriteDataIn     (RegWriteDataIn),
    .CancelValidIn      (CancelValidIn),
    .CancelDestRegIn    (CancelDestRegIn),
    .StallOut           (StallOut),
    .ScoreboardErrorOut (ScoreboardErrorOut)
  );

  typedef struct {
    bit        rst;
    bit [4:0]  r1, r2;
    bit        u1, u2;
    bit        iw;
    bit [4:0]  id;
    bit        wb;
    bit [4:0]  wd;
    bit [31:0] wdata;
    bit        cv;
    bit [4:0]  cd;
  } stim_t;

  typedef struct {
    int        cyc;
    bit [31:0] rd1, rd2;
    bit        stall, err;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] m_regs[32];
  int        m_cnt[32];
  bit        m_err;
  int        cycle;
  int        tests;
  int        fails;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic int mdec(stim_t s, int r);
    int d;
    d = 0;
    if (s.wb && s.wd != 0 && int'(s.wd) == r) d++;
    if (s.cv && s.cd != 0 && int'(s.cd) == r) d++;
    return d;
  endfunction

  function automatic bit [31:0] mread(stim_t s, bit [4:0] a);
    if (a == 0) return 32'h0;
    if (s.wb && s.wd == a) return s.wdata;
    return m_regs[a];
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   raw1, raw2, full;
    int   n;
    @(posedge Clk);
    #1;
    Rst              = s.rst;
    ReadReg1In       = s.r1;
    ReadReg2In       = s.r2;
    Use1In           = s.u1;
    Use2In           = s.u2;
    IssueRegWriteIn  = s.iw;
    IssueDestRegIn   = s.id;
    RegWriteIn       = s.wb;
    DestinationRegIn = s.wd;
    RegWriteDataIn   = s.wdata;
    CancelValidIn    = s.cv;
    CancelDestRegIn  = s.cd;
    raw1 = s.u1 && s.r1 != 0 && m_cnt[s.r1] > mdec(s, int'(s.r1));
    raw2 = s.u2 && s.r2 != 0 && m_cnt[s.r2] > mdec(s, int'(s.r2));
    full = s.iw && s.id != 0 && (m_cnt[s.id] - mdec(s, int'(s.id))) >= MAXF;
    e.cyc   = cycle;
    e.rd1   = mread(s, s.r1);
    e.rd2   = mread(s, s.r2);
    e.stall = raw1 || raw2 || full;
    e.err   = m_err;
    exp_q.push_back(e);
    if (s.rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 1'b0;
    end else begin
      if (s.wb && s.wd != 0) m_regs[s.wd] = s.wdata;
      for (int r = 1; r < 32; r++) begin
        n = m_cnt[r] - mdec(s, r);
        if (s.iw && !e.stall && int'(s.id) == r) n++;
        if (n < 0) begin
          n = 0;
          m_err = 1'b1;
        end else if (n > MAXF) begin
          n = MAXF;
          m_err = 1'b1;
        end
        m_cnt[r] = n;
      end
    end
    cycle++;
  endtask

  task automatic checkOutput(input exp_t e);
    tests++;
    if (ReadData1Out !== e.rd1) begin
      fails++;
      $display("[TB] FAIL rd1 cyc%0d got %h want %h", e.cyc, ReadData1Out, e.rd1);
    end
    tests++;
    if (ReadData2Out !== e.rd2) begin
      fails++;
      $display("[TB] FAIL rd2 cyc%0d got %h want %h", e.cyc, ReadData2Out, e.rd2);
    end
    tests++;
    if (StallOut !== e.stall) begin
      fails++;
      $display("[TB] FAIL stall cyc%0d got %b want %b", e.cyc, StallOut, e.stall);
    end
    tests++;
    if (ScoreboardErrorOut !== e.err) begin
      fails++;
      $display("[TB] FAIL err cyc%0d got %b want %b", e.cyc, ScoreboardErrorOut, e.err);
    end
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin : driver
    stim_t s;
    tests = 0;
    fails = 0;
    cycle = 0;
    m_err = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    Rst = 1'b1;
    ReadReg1In = '0; ReadReg2In = '0; Use1In = 0; Use2In = 0;
    IssueRegWriteIn = 0; IssueDestRegIn = '0; RegWriteIn = 0;
    DestinationRegIn = '0; RegWriteDataIn = '0; CancelValidIn = 0; CancelDestRegIn = '0;

    s = idle(); s.rst = 1; s.r2 = 5;
    repeat (2) applyStimulus(s);
    s = idle(); s.r2 = 5; s.wb = 1; s.wd = 5; s.wdata = 32'hDEADBEEF;
    applyStimulus(s);
    s = idle(); s.r1 = 5;
    applyStimulus(s);
    s = idle(); s.wb = 1; s.wd = 0; s.wdata = 32'h1234; s.r1 = 0; s.r2 = 5;
    applyStimulus(s);
    s = idle(); s.r1 = 0; s.r2 = 5;
    applyStimulus(s);
    s = idle(); s.wb = 1; s.wd = 9; s.wdata = 32'hA5A5A5A5; s.r1 = 9;
    applyStimulus(s);

    // RAW hazard on r8, released by its own write-back.
    s = idle(); s.iw = 1; s.id = 8;
    applyStimulus(s);
    s = idle(); s.u1 = 1; s.r1 = 8;
    applyStimulus(s);
    s.wb = 1; s.wd = 8; s.wdata = 32'h0BADF00D;
    applyStimulus(s);
    s = idle(); s.u1 = 1; s.r1 = 8;
    applyStimulus(s);

    // Fill r3 to the in-flight limit, then drain it.
    s = idle(); s.iw = 1; s.id = 3;
    repeat (5) applyStimulus(s);
    s.wb = 1; s.wd = 3; s.wdata = 32'h33333333;
    applyStimulus(s);
    s = idle(); s.u2 = 1; s.r2 = 3; s.wb = 1; s.wd = 3;
    for (int i = 0; i < 4; i++) begin
      s.wdata = $urandom;
      applyStimulus(s);
    end
    s = idle(); s.u2 = 1; s.r2 = 3;
    applyStimulus(s);

    // Combined write-back + cancel, then an underflow that sticks.
    s = idle(); s.iw = 1; s.id = 7;
    repeat (2) applyStimulus(s);
    s = idle(); s.wb = 1; s.wd = 7; s.cv = 1; s.cd = 7; s.wdata = 32'h77777777;
    applyStimulus(s);
    s = idle(); s.u1 = 1; s.r1 = 7;
    applyStimulus(s);
    s = idle(); s.wb = 1; s.wd = 7; s.wdata = 32'h70707070;
    applyStimulus(s);
    s = idle(); s.r1 = 7;
    repeat (3) applyStimulus(s);
    s.rst = 1;
    applyStimulus(s);
    s = idle();
    applyStimulus(s);

    // Reset landing on a write-back cycle with r4 pending.
    s = idle(); s.iw = 1; s.id = 4;
    repeat (2) applyStimulus(s);
    s = idle(); s.rst = 1; s.wb = 1; s.wd = 4; s.wdata = 32'h44444444; s.iw = 1; s.id = 4;
    applyStimulus(s);
    s = idle(); s.u1 = 1; s.r1 = 4; s.u2 = 1; s.r2 = 5;
    applyStimulus(s);

    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 49) == 0);
      s.r1    = 5'($urandom_range(0, 7));
      s.r2    = 5'($urandom_range(0, 7));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.iw    = ($urandom_range(0, 2) != 0);
      s.id    = 5'($urandom_range(0, 7));
      s.wb    = ($urandom_range(0, 2) == 0);
      s.wd    = 5'($urandom_range(0, 7));
      s.wdata = $urandom;
      s.cv    = ($urandom_range(0, 7) == 0);
      s.cd    = 5'($urandom_range(0, 7));
      applyStimulus(s);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
